mips_trace_monitor: RTL and testbench
=====================================

// Module: mips_trace_monitor
// PURPOSE
//  Parametrised run-control and writeback trace unit for the MIPS core; successor to fixed-window register dumps.
//  Sits beside the core: snoops PC and register-file writebacks, buffers them in a FWFT trace FIFO,
//  and halts the run on PC breakpoint or cycle budget, so benches/debug logic stop on events, not fixed time.
// PARAMETERS
//  DATA_W   32  width of writeback data and trace_data
//  PC_W     32  width of pc_in, bp_pc, trace_pc
//  REG_AW   5   register address width (wb_addr, trace_addr)
//  DEPTH    16  trace FIFO entries; power of 2, >=2
//  CNT_W    16  width of cycle_count and cycle_limit
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              reset, asynchronous, active-low
//  start        in   1              IDLE->RUN request (level; sampled in IDLE only)
//  clear        in   1              sync restart: FIFO, counters, flags, state->IDLE
//  pc_in        in   PC_W           core PC of instruction in writeback
//  wb_valid     in   1              register-file write this cycle
//  wb_addr      in   REG_AW         destination register
//  wb_data      in   DATA_W         write data
//  bp_enable    in   1              breakpoint compare enable
//  bp_pc        in   PC_W           breakpoint PC
//  cycle_limit  in   CNT_W          RUN-cycle budget; 0 = unlimited
//  core_stall   out  1              high in IDLE and HALTED; core must hold state
//  halt_cause   out  2              b01 breakpoint, b10 cycle limit, b11 both, b00 none
//  cycle_count  out  CNT_W          RUN cycles elapsed, saturating
//  trace_valid  out  1              FIFO head valid (FWFT)
//  trace_ready  in   1              consumer pops head when valid&&ready
//  trace_pc     out  PC_W           head entry PC
//  trace_addr   out  REG_AW         head entry register
//  trace_data   out  DATA_W         head entry data
//  trace_level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow     out  1              sticky: >=1 capture dropped because FIFO full
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE; core_stall=1; halt_cause=0; cycle_count=0; trace_valid=0;
//   trace_level=0; overflow=0; trace_pc/addr/data=0. clear has identical effect, synchronously.
//  FSM: IDLE -(start)-> RUN; RUN -(halt event)-> HALTED; HALTED exits only via clear/reset.
//   clear takes priority over every other event in the same cycle.
//  RUN, each cycle: cycle_count +1, saturates at all-ones.
//   Capture when wb_valid && wb_addr!=0; writes to register 0 never captured.
//   Halt event bp: bp_enable && pc_in==bp_pc. Halt event lim: cycle_limit!=0 && cycle_count+1==cycle_limit.
//   On halt event: next state HALTED, halt_cause set (both -> b11); that cycle's capture still recorded;
//   core_stall high from the following cycle. halt_cause holds until clear/reset.
//  IDLE/HALTED: no capture, cycle_count frozen; FIFO readout continues.
//  FIFO: FWFT; entry {pc,addr,data} pushed in cycle N is on trace_* in N+1 if FIFO was empty.
//   Pop when trace_valid && trace_ready; trace_* change only on pop or push-into-empty.
//   Full + capture without pop: entry dropped, overflow set, trace_level stays DEPTH.
//   Full + capture + pop same cycle: both occur, no drop, level stays DEPTH.
//   Empty + ready: no-op. Pointers wrap modulo DEPTH; level counts 0..DEPTH exactly.
//  All outputs registered; no combinational path input->output except none required.
// TESTING
//  1 Reset mid-RUN with 5 entries buffered -> next edge: trace_level=0, trace_valid=0, core_stall=1, cycle_count=0.
//  2 start; wb writes r8=0x11 @pc 0x0, r0=0x99 @pc 0x4, r9=0x22 @pc 0x8 -> trace pops (0x0,8,0x11),(0x8,9,0x22); level max 2.
//  3 bp_enable=1, bp_pc=0x14, wb r10=0x33 @pc 0x14 -> entry (0x14,10,0x33) captured; halt_cause=b01;
//    core_stall=1 next cycle; later wb_valid pulses not captured; cycle_count frozen.
//  4 cycle_limit=20, no bp -> after 20 RUN cycles cycle_count=20, halt_cause=b10; with bp hit same cycle -> b11.
//  5 DEPTH=16, ready=0, 18 captures -> level=16, overflow=1, head = first entry; then ready=1 with
//    continuous capture -> level holds 16, no further drops, overflow stays 1 until clear.
//  6 clear asserted together with start and bp hit -> state IDLE, halt_cause=0, FIFO empty.

Source files
------------

// File: rtl/mips_trace_monitor_if.sv
// Trace readout stream of mips_trace_monitor.
//   master : monitor side, drives valid/pc/addr/data and samples ready
//   slave  : consumer side, samples the head entry and drives ready
// The head entry is popped on any rising edge where valid && ready.
interface mips_trace_monitor_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [REG_AW-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output pc, output addr, output data, input ready);
  modport slave  (input valid, input pc, input addr, input data, output ready);
endinterface

// File: rtl/mips_trace_monitor.sv
// Run-control and writeback trace unit for the MIPS core.
// Snoops the writeback stage while running, buffers {pc, reg, data} of every
// non-r0 register write in a first-word-fall-through FIFO, and halts the run on
// a PC breakpoint or when the cycle budget is used up.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, clear          run request (IDLE only), synchronous restart
//   pc_in, wb_*           writeback stage snoop
//   bp_enable, bp_pc      PC breakpoint
//   cycle_limit           run-cycle budget, 0 = unlimited
//   core_stall            hold the core (IDLE and HALTED)
//   halt_cause            {limit, breakpoint}
//   cycle_count           saturating count of RUN cycles
//   trace_level, overflow FIFO fill level and sticky drop flag
//   trace                 FIFO head stream (master side)
module mips_trace_monitor #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     wb_valid,
  input  logic [REG_AW-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     bp_enable,
  input  logic [PC_W-1:0]          bp_pc,
  input  logic [CNT_W-1:0]         cycle_limit,
  output logic                     core_stall,
  output logic [1:0]               halt_cause,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [$clog2(DEPTH):0]   trace_level,
  output logic                     overflow,
  mips_trace_monitor_if.master     trace
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = PC_W + REG_AW + DATA_W;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e          state_q;
  logic [CNT_W:0]  cnt_inc;
  logic            bp_hit, lim_hit, capture, pop, full, push, drop;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [LW-1:0]   level_q, level_d;
  logic            valid_q, ovf_q;
  logic [EW-1:0]   head_q, wr_entry;

  always_comb begin
    cnt_inc  = {1'b0, cycle_count} + 1'b1;
    bp_hit   = bp_enable && (pc_in == bp_pc);
    // Compare one bit wider so a saturated counter never aliases onto the limit.
    lim_hit  = (cycle_limit != '0) && (cnt_inc == {1'b0, cycle_limit});
    capture  = (state_q == StRun) && wb_valid && (wb_addr != '0);
    pop      = valid_q && trace.ready;
    full     = (level_q == LW'(DEPTH));
    // A pop frees the slot a same-cycle capture needs when full.
    push     = capture && (!full || pop);
    drop     = capture && full && !pop;
    level_d  = level_q + LW'(push) - LW'(pop);
    rd_next  = rd_ptr_q + AW'(1);
    wr_entry = {pc_in, wb_addr, wb_data};
  end

  // Run-control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      core_stall  <= 1'b1;
      halt_cause  <= 2'b00;
      cycle_count <= '0;
    end else if (clear) begin
      state_q     <= StIdle;
      core_stall  <= 1'b1;
      halt_cause  <= 2'b00;
      cycle_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            core_stall <= 1'b0;
          end
        end
        StRun: begin
          if (cycle_count != '1) cycle_count <= cnt_inc[CNT_W-1:0];
          if (bp_hit || lim_hit) begin
            state_q    <= StHalted;
            core_stall <= 1'b1;
            halt_cause <= {lim_hit, bp_hit};
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q    <= StIdle;
          core_stall <= 1'b1;
        end
      endcase
    end
  end

  // Storage; mem[rd_ptr_q] always mirrors head_q while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_next;
      level_q <= level_d;
      valid_q <= (level_d != '0);
      if (drop) ovf_q <= 1'b1;
      // Head reloads from the incoming write when it becomes the only entry,
      // otherwise from the next stored entry on a pop.
      if (push && ((level_q == '0) || (pop && (level_q == LW'(1))))) begin
        head_q <= wr_entry;
      end else if (pop && (level_q > LW'(1))) begin
        head_q <= mem[rd_next];
      end
    end
  end

  assign trace_level = level_q;
  assign overflow    = ovf_q;
  assign trace.valid = valid_q;
  assign trace.pc    = head_q[EW-1 -: PC_W];
  assign trace.addr  = head_q[DATA_W +: REG_AW];
  assign trace.data  = head_q[DATA_W-1:0];

endmodule

// File: tb/tb_mips_trace_monitor.sv
module tb_mips_trace_monitor;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, clear, wb_valid, bp_enable;
  logic [PC_W-1:0]   pc_in, bp_pc;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  cycle_limit;
  logic              core_stall, overflow;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_count;
  logic [LW-1:0]     trace_level;

  mips_trace_monitor_if #(.PC_W(PC_W), .REG_AW(REG_AW), .DATA_W(DATA_W)) tif ();

  mips_trace_monitor #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .pc_in(pc_in), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .bp_enable(bp_enable), .bp_pc(bp_pc), .cycle_limit(cycle_limit),
    .core_stall(core_stall), .halt_cause(halt_cause), .cycle_count(cycle_count),
    .trace_level(trace_level), .overflow(overflow), .trace(tif)
  );

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wv;
    int unsigned       exp_level;
  } vec_t;

  typedef enum {MIdle, MRun, MHalt} mst_e;

  ent_t             sb[$];
  mst_e             m_state;
  logic [CNT_W-1:0] m_cnt;
  logic [1:0]       m_cause;
  logic             m_ovf;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ent_t head();
    return '{pc: tif.pc, addr: tif.addr, data: tif.data};
  endfunction

  task automatic model_reset();
    sb.delete();
    m_state = MIdle;
    m_cnt   = '0;
    m_cause = 2'b00;
    m_ovf   = 1'b0;
  endtask

  // One clock: update the model from the inputs now driven, clock, then compare.
  task automatic tick();
    logic             cap, bp, lim, pop;
    logic [CNT_W:0]   inc;
    cap = (m_state == MRun) && wb_valid && (wb_addr != '0);
    bp  = bp_enable && (pc_in == bp_pc);
    inc = {1'b0, m_cnt} + 1'b1;
    lim = (cycle_limit != '0) && (inc == {1'b0, cycle_limit});
    pop = tif.ready && (sb.size() != 0);
    check("trace_valid", 128'(tif.valid), 128'(sb.size() != 0));
    if (pop) check("trace_head", 128'(head()), 128'(sb[0]));
    if (clear) begin
      model_reset();
    end else begin
      if (pop) sb.delete(0);
      if (cap) begin
        if (sb.size() < DEPTH) sb.push_back('{pc: pc_in, addr: wb_addr, data: wb_data});
        else m_ovf = 1'b1;
      end
      case (m_state)
        MIdle: if (start) m_state = MRun;
        MRun: begin
          if (m_cnt != '1) m_cnt = inc[CNT_W-1:0];
          if (bp || lim) begin
            m_cause = {lim, bp};
            m_state = MHalt;
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check("trace_level", 128'(trace_level), 128'(sb.size()));
    check("core_stall", 128'(core_stall), 128'(m_state != MRun));
    check("cycle_count", 128'(cycle_count), 128'(m_cnt));
    check("halt_cause", 128'(halt_cause), 128'(m_cause));
    check("overflow", 128'(overflow), 128'(m_ovf));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_level", 128'(trace_level), 128'(0));
    check("rst_valid", 128'(tif.valid), 128'(0));
    check("rst_stall", 128'(core_stall), 128'(1));
    check("rst_count", 128'(cycle_count), 128'(0));
    check("rst_cause", 128'(halt_cause), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_head", 128'(head()), 128'(0));
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic wb(input logic [PC_W-1:0] pc, input logic [REG_AW-1:0] a,
                    input logic [DATA_W-1:0] d);
    wb_valid = 1'b1;
    pc_in    = pc;
    wb_addr  = a;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t             vecs[4];
    logic [CNT_W-1:0] frozen;
    ent_t             first;

    vecs[0] = '{pc: 32'h0, addr: 5'd8, data: 32'h11, wv: 1'b1, exp_level: 1};
    vecs[1] = '{pc: 32'h4, addr: 5'd0, data: 32'h99, wv: 1'b1, exp_level: 1};
    vecs[2] = '{pc: 32'h8, addr: 5'd9, data: 32'h22, wv: 1'b1, exp_level: 2};
    vecs[3] = '{pc: 32'hc, addr: 5'd7, data: 32'h55, wv: 1'b0, exp_level: 2};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; wb_valid = 1'b0; bp_enable = 1'b0;
    pc_in = '0; bp_pc = '0; wb_addr = '0; wb_data = '0; cycle_limit = '0;
    tif.ready = 1'b0;
    model_reset();
    apply_reset();

    // Reset in the middle of a run with five entries buffered.
    pulse_start();
    for (int i = 0; i < 5; i++) wb(PC_W'(i * 4), REG_AW'(i + 1), DATA_W'(32'hA0 + i));
    check("t1_level5", 128'(trace_level), 128'(5));
    apply_reset();

    // Table vectors: r0 write and idle wb are not captured.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wb_valid = vecs[i].wv;
      pc_in    = vecs[i].pc;
      wb_addr  = vecs[i].addr;
      wb_data  = vecs[i].data;
      tick();
      check("vec_level", 128'(trace_level), 128'(vecs[i].exp_level));
    end
    wb_valid  = 1'b0;
    tif.ready = 1'b1;
    check("t2_head0", 128'(head()), 128'(ent_t'({32'h0, 5'd8, 32'h11})));
    tick();
    check("t2_head1", 128'(head()), 128'(ent_t'({32'h8, 5'd9, 32'h22})));
    tick();
    tick();
    tif.ready = 1'b0;
    check("t2_drained", 128'(trace_level), 128'(0));

    // Breakpoint: the hitting writeback is still captured.
    bp_enable = 1'b1;
    bp_pc     = 32'h14;
    wb(32'h10, 5'd3, 32'h30);
    wb(32'h14, 5'd10, 32'h33);
    check("t3_cause", 128'(halt_cause), 128'(2'b01));
    check("t3_stall", 128'(core_stall), 128'(1));
    frozen = cycle_count;
    bp_enable = 1'b0;
    for (int i = 0; i < 3; i++) wb(PC_W'(32'h18 + i * 4), REG_AW'(11 + i), DATA_W'(i));
    check("t3_frozen", 128'(cycle_count), 128'(frozen));
    check("t3_level", 128'(trace_level), 128'(2));
    tif.ready = 1'b1;
    tick();
    check("t3_bp_entry", 128'(head()), 128'(ent_t'({32'h14, 5'd10, 32'h33})));
    tick();
    tick();
    tif.ready = 1'b0;

    // Cycle limit alone, then together with a breakpoint on the same cycle.
    pulse_clear();
    cycle_limit = 16'd20;
    pc_in       = '0;
    pulse_start();
    for (int i = 0; i < 40 && core_stall == 1'b0; i++) tick();
    check("t4_count", 128'(cycle_count), 128'(20));
    check("t4_cause", 128'(halt_cause), 128'(2'b10));
    pulse_clear();
    bp_enable = 1'b1;
    bp_pc     = 32'h200;
    pulse_start();
    for (int i = 0; i < 19; i++) tick();
    pc_in = 32'h200;
    tick();
    check("t4_both", 128'(halt_cause), 128'(2'b11));
    check("t4_count2", 128'(cycle_count), 128'(20));
    bp_enable = 1'b0;
    pc_in = '0;
    cycle_limit = '0;
    pulse_clear();

    // Overflow: 18 captures into a 16-deep FIFO, then full-rate pop+push.
    pulse_start();
    for (int i = 0; i < 18; i++)
      wb(PC_W'(i * 4), REG_AW'((i % 31) + 1), DATA_W'(32'h1000 + i));
    first = '{pc: 32'h0, addr: 5'd1, data: 32'h1000};
    check("t5_level", 128'(trace_level), 128'(DEPTH));
    check("t5_ovf", 128'(overflow), 128'(1));
    check("t5_head", 128'(head()), 128'(first));
    tif.ready = 1'b1;
    for (int i = 18; i < 38; i++)
      wb(PC_W'(i * 4), REG_AW'((i % 31) + 1), DATA_W'(32'h1000 + i));
    check("t5_level_hold", 128'(trace_level), 128'(DEPTH));
    check("t5_ovf_hold", 128'(overflow), 128'(1));
    for (int i = 0; i < 17; i++) tick();
    check("t5_drained", 128'(trace_level), 128'(0));
    tif.ready = 1'b0;
    pulse_clear();
    check("t5_ovf_clr", 128'(overflow), 128'(0));

    // clear beats start and a breakpoint hit in the same cycle.
    pulse_start();
    wb(32'h40, 5'd4, 32'h44);
    wb(32'h44, 5'd5, 32'h45);
    clear     = 1'b1;
    start     = 1'b1;
    bp_enable = 1'b1;
    bp_pc     = 32'h48;
    wb(32'h48, 5'd6, 32'h46);
    clear = 1'b0;
    start = 1'b0;
    bp_enable = 1'b0;
    check("t6_cause", 128'(halt_cause), 128'(0));
    check("t6_level", 128'(trace_level), 128'(0));
    check("t6_stall", 128'(core_stall), 128'(1));
    tick();
    check("t6_idle", 128'(core_stall), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
